// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, decrypt FSM states and GF(2^8) helpers used to build the inverse S-box.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int BYTE_W = 8;
  localparam int SBOX_DEPTH = 256;
  typedef enum logic [1:0] {INIT, IDLE, RUN, DONE} state_t;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse and maps 0 to 0 as required
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction
endpackage

// File: rtl/inv_s_box_maker.sv
// inv_s_box_maker: walks addresses 0..255 after reset producing inverse S-box write data, then flags ready.
module inv_s_box_maker
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic              wr_enable,
  output logic [BYTE_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              done,
  output logic              ready
);
  logic [BYTE_W:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      ready <= 1'b0;
    end else begin
      cnt <= cnt[BYTE_W] ? cnt : cnt + 1'b1;
      ready <= ready | cnt[BYTE_W];
    end
  assign done = cnt[BYTE_W];
  assign wr_enable = !cnt[BYTE_W];
  assign wr_addr = cnt[BYTE_W-1:0];
  assign wr_data = gf_inv(inv_affine(cnt[BYTE_W-1:0]));
endmodule

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: AES InvSubBytes, LANES bytes per cycle through LANES copies of a RAM-built inverse S-box.
module inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   in_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   out_ready,
  output logic                   s_box_ready,
  output logic                   busy
);
  localparam int N = AES_BLOCK_W / BYTE_W / LANES;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t state;
  logic [CW-1:0] cnt, wr_grp;
  logic drain, wr_vld, wr_enable, init_done;
  logic [BYTE_W-1:0] wr_addr, wr_data;
  logic [AES_BLOCK_W-1:0] cap;
  logic [LANES*BYTE_W-1:0] rd_bus;
  inv_s_box_maker maker (
    .clk(clk),
    .reset(reset),
    .wr_enable(wr_enable),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .done(init_done),
    .ready(s_box_ready)
  );
  for (genvar g = 0; g < LANES; g++) begin : g_ram
    logic [BYTE_W-1:0] mem [SBOX_DEPTH];
    logic [BYTE_W-1:0] ra, q;
    always_comb ra = cap[AES_BLOCK_W-1-BYTE_W*(int'(cnt)*LANES+g) -: BYTE_W];
    always_ff @(posedge clk) begin
      if (wr_enable) mem[wr_addr] <= wr_data;
      q <= mem[ra];
    end
    assign rd_bus[BYTE_W*(LANES-1-g) +: BYTE_W] = q;
  end
  // RAM read is one cycle behind addressing, so the last group needs one drain cycle before DONE
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      cnt <= '0;
      drain <= 1'b0;
      wr_vld <= 1'b0;
      wr_grp <= '0;
      cap <= '0;
      out_data <= '0;
      out_ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      wr_vld <= state == RUN && !drain;
      wr_grp <= cnt;
      out_ready <= 1'b0;
      if (wr_vld)
        for (int i = 0; i < LANES; i++)
          out_data[AES_BLOCK_W-1-BYTE_W*(int'(wr_grp)*LANES+i) -: BYTE_W] <= rd_bus[BYTE_W*(LANES-1-i) +: BYTE_W];
      case (state)
        INIT: state <= init_done ? IDLE : INIT;
        IDLE, DONE:
          if (in_ready) begin
            cap <= in_data;
            cnt <= '0;
            drain <= 1'b0;
            state <= RUN;
            busy <= 1'b1;
          end else state <= IDLE;
        RUN:
          if (cnt != LAST) cnt <= cnt + 1'b1;
          else if (!drain) drain <= 1'b1;
          else begin
            state <= DONE;
            cnt <= '0;
            drain <= 1'b0;
            out_ready <= 1'b1;
            busy <= 1'b0;
          end
        default: state <= INIT;
      endcase
    end
endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb_inv_sub_bytes: scoreboard bench driving LANES=4/8/16 instances against a golden inverse S-box table.
module tb_inv_sub_bytes;
  localparam logic [2047:0] INV_SBOX = {
    128'h52096AD53036A538BF40A39E81F3D7FB, 128'h7CE339829B2FFF87348E4344C4DEE9CB,
    128'h547B9432A6C2233DEE4C950B42FAC34E, 128'h082EA16628D924B2765BA2496D8BD125,
    128'h72F8F66486689816D4A45CCC5D65B692, 128'h6C704850FDEDB9DA5E154657A78D9D84,
    128'h90D8AB008CBCD30AF7E45805B8B34506, 128'hD02C1E8FCA3F0F02C1AFBD0301138A6B,
    128'h3A9111414F67DCEA97F2CFCEF0B4E673, 128'h96AC7422E7AD3585E2F937E81C75DF6E,
    128'h47F11A711D29C5896FB7620EAA18BE1B, 128'hFC563E4BC6D279209ADBC0FE78CD5AF4,
    128'h1FDDA8338807C731B11210592780EC5F, 128'h60517FA919B54A0D2DE57A9F93C99CEF,
    128'hA0E03B4DAE2AF5B0C8EBBB3C83539961, 128'h172B047EBA77D626E169146355210C7D};
  localparam logic [127:0] V3_IN = 128'h637C777BF26B6FC53001672BFED7AB76;
  localparam logic [127:0] V3_OUT = 128'h000102030405060708090A0B0C0D0E0F;
  typedef struct {
    logic [127:0] data;
    int acc;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [127:0] in_data = '0;
  logic in_ready[3] = '{default: 1'b0};
  logic [127:0] od[3];
  logic ordy[3], sbr[3], bsy[3];
  exp_t sb[3][$];
  int last_or[3] = '{default: -1};
  logic b2b[3] = '{default: 1'b0};
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [7:0] isb(input logic [7:0] x);
    return INV_SBOX[2047-8*int'(x) -: 8];
  endfunction
  function automatic logic [127:0] inv_block(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = isb(d[127-8*k -: 8]);
    return r;
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = 16 / (4 << g) + 1;
    inv_sub_bytes #(.LANES(4 << g)) dut (
      .clk(clk),
      .reset(reset),
      .in_data(in_data),
      .in_ready(in_ready[g]),
      .out_data(od[g]),
      .out_ready(ordy[g]),
      .s_box_ready(sbr[g]),
      .busy(bsy[g])
    );
    always @(negedge clk)
      if (ordy[g]) begin : mon
        exp_t e;
        if (sb[g].size() == 0) fail($sformatf("unexpected_out_ready_l%0d at cycle %0d", 4 << g, cyc));
        else begin
          e = sb[g].pop_front();
          check($sformatf("data_l%0d", 4 << g), od[g], e.data);
          if (e.acc >= 0) check($sformatf("latency_l%0d", 4 << g), 128'(cyc - e.acc), 128'(LAT));
        end
        if (b2b[g] && last_or[g] >= 0) check($sformatf("period_l%0d", 4 << g), 128'(cyc - last_or[g]), 128'(LAT + 1));
        last_or[g] = cyc;
      end
  end
  function automatic logic all_idle(input logic [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i] && (bsy[i] || !sbr[i])) return 1'b0;
    return 1'b1;
  endfunction
  task automatic wait_idle(input logic [2:0] m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 400 && !all_idle(m));
    if (!all_idle(m)) fail("idle_timeout");
  endtask
  task automatic send(input logic [2:0] m, input logic [127:0] d, input logic [127:0] e);
    wait_idle(m);
    in_data = d;
    for (int i = 0; i < 3; i++)
      if (m[i]) begin
        in_ready[i] = 1'b1;
        sb[i].push_back('{e, cyc + 1});
      end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_ready[i] = 1'b0;
      if (m[i]) check($sformatf("busy_after_accept_l%0d", 4 << i), 128'(bsy[i]), 128'(1));
    end
  endtask
  task automatic drain();
    int n = 0;
    while (n < 100 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
      @(negedge clk);
      n++;
    end
    if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) fail("drain_timeout");
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int rise[3];
    int n;
    logic [127:0] d;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_data_l%0d", 4 << i), od[i], 128'h0);
      check($sformatf("reset_ctrl_l%0d", 4 << i), {125'h0, ordy[i], sbr[i], bsy[i]}, 128'h0);
    end
    reset = 1'b1;
    rise = '{default: 0};
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        in_ready[i] = c == 100;
        if (sbr[i] && rise[i] == 0) rise[i] = c;
      end
    end
    for (int i = 0; i < 3; i++) check($sformatf("s_box_ready_rise_l%0d", 4 << i), 128'(rise[i]), 128'(257));
    send(3'b111, {16{8'h63}}, 128'h0);
    send(3'b111, V3_IN, V3_OUT);
    send(3'b111, 128'h0016ED7C637C777BF26B6FC53001672B, 128'h52FF5301000102030405060708090A0B);
    send(3'b001, 128'hFED7AB76637C777BF26B6FC53001672B, 128'h0C0D0E0F000102030405060708090A0B);
    @(negedge clk);
    in_data = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    in_ready[0] = 1'b1;
    @(negedge clk);
    in_ready[0] = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int j = 0; j < 16; j++) d[127-8*j -: 8] = 8'(b * 16 + j);
      send(3'b111, d, inv_block(d));
    end
    drain();
    wait_idle(3'b001);
    in_data = V3_IN;
    for (int k = 0; k < 3; k++) sb[0].push_back('{V3_OUT, -1});
    last_or[0] = -1;
    b2b[0] = 1'b1;
    in_ready[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      if (ordy[0]) n++;
    end
    in_ready[0] = 1'b0;
    check("b2b_pulses", 128'(n), 128'(3));
    repeat (10) @(negedge clk);
    b2b[0] = 1'b0;
    check("b2b_no_extra_accept", 128'(bsy[0]), 128'(0));
    check("b2b_queue_empty", 128'(sb[0].size()), 128'(0));
    send(3'b111, V3_IN, V3_OUT);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midreset_data_l%0d", 4 << i), od[i], 128'h0);
      check($sformatf("midreset_ctrl_l%0d", 4 << i), {125'h0, ordy[i], sbr[i], bsy[i]}, 128'h0);
      sb[i].delete();
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    send(3'b111, V3_IN, V3_OUT);
    send(3'b111, {16{8'h63}}, 128'h0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
